// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

    // Default operand/result width in bits (legal range 2..32).
    localparam int DEFAULT_WIDTH = 8;

    // Control FSM states. busy is exactly RUN, done is exactly DONE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Gate-level one-bit full adder cell (module full_adder).
// Port order is (s, c_out, a, b, c_in).
module full_adder (
    output logic s,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    logic p;

    // Propagate term shared by the sum and the carry.
    assign p     = a ^ b;
    assign s     = p ^ c_in;
    assign c_out = (a & b) | (c_in & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in LSB-first,
// one bit per clock, through a single full_adder cell and a registered
// carry loop.
//
// Build option: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf. Without it the port and its logic are absent.
//
// Handshake: start is accepted on a rising edge only while busy=0
// (state IDLE or DONE); a, b and c_in are sampled on that edge only.
// busy is high for the WIDTH cycles of RUN, done pulses for one cycle
// afterwards, and sum/c_out(/ovf) stay stable from done until the next
// accepted start. start while busy is dropped without any indication.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Bit counter just wide enough to index the operand bits.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // FSM state, visible by name for checkers bound to this module.
    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             accept;
    logic             last_bit;

    // A new operation is taken only when no addition is in progress.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (cnt == LAST_BIT);

    // Single full adder works on the current LSBs and the carry loop.
    full_adder u_cell (
        .s     (s),
        .c_out (co),
        .a     (sa[0]),
        .b     (sb[0]),
        .c_in  (cy)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs decoded straight from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand shift registers, carry loop, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            cy  <= c_in;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            sum <= {s, sum[WIDTH-1:1]};
            cy  <= co;
            if (last_bit) begin
                // Counter holds on the final bit so it never wraps.
                c_out <= co;
`ifdef SERIAL_ADDER_OVF_EN
                // Carry into the MSB differs from carry out of it.
                ovf   <= cy ^ co;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): table of operand/result
// records plus hand-written sequences for ignored start, reset abort and
// back-to-back operation with start held high.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[10];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; returns the cycle count at which done is seen
    // and how many sampled cycles had busy=1 on the way. Bounded.
    task automatic wait_done(output int at_cyc, output int busy_cnt);
        int guard;
        guard = 0;
        busy_cnt = 0;
        while (!done && guard < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        at_cyc = cyc;
        if (!done) begin
            checks++;
            $display("FAIL wait_done: no done within %0d cycles", guard);
        end
    endtask

    // Drive one start pulse at a negedge; returns cycle of the accepting edge.
    task automatic pulse_start(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vc, output int acc_cyc);
        start = 1'b1;
        a     = va;
        b     = vb;
        c_in  = vc;
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        start = 1'b0;
    endtask

    // Full single operation with result, latency and done-width checks.
    task automatic run_vec(input int idx);
        int acc, fin, nbusy;
        pulse_start(vecs[idx].a, vecs[idx].b, vecs[idx].cin, acc);
        wait_done(fin, nbusy);
        check($sformatf("v%0d latency", idx), fin - acc, W);
        check($sformatf("v%0d busy_cycles", idx), nbusy, W);
        check($sformatf("v%0d sum", idx), sum, vecs[idx].sum);
        check($sformatf("v%0d c_out", idx), c_out, vecs[idx].cout);
`ifdef SERIAL_ADDER_OVF_EN
        check($sformatf("v%0d ovf", idx), ovf, vecs[idx].ovf);
`endif
        check($sformatf("v%0d busy_at_done", idx), busy, 0);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d done_width", idx), done, 0);
        check($sformatf("v%0d sum_hold", idx), sum, vecs[idx].sum);
    endtask

    initial begin
        int acc, fin, nbusy, ndone, prev;
        logic [W-1:0] bb_a[3];
        logic [W-1:0] bb_b[3];
        logic         bb_c[3];
        logic [W-1:0] bb_s[3];
        logic         bb_co[3];

        // {a, b, c_in, sum, c_out, ovf}
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hC8, 8'hC8, 1'b0, 8'h90, 1'b1, 1'b0};
        vecs[8] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};
        vecs[9] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset block.
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        #2;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset c_out", c_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) run_vec(i);

        // start pulsed at cycle 3 of RUN is ignored.
        pulse_start(8'h5A, 8'h3C, 1'b0, acc);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(fin, nbusy);
        check("ignore latency", fin - acc, W);
        check("ignore sum", sum, 8'h96);
        check("ignore c_out", c_out, 0);
        @(posedge clk);
        @(negedge clk);
        check("ignore no_restart busy", busy, 0);

        // Reset at cycle 4 of RUN aborts without done.
        pulse_start(8'hFF, 8'hFF, 1'b1, acc);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort sum", sum, 0);
        check("abort c_out", c_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort no_done", ndone, 0);
        pulse_start(8'h01, 8'h02, 1'b0, acc);
        wait_done(fin, nbusy);
        check("post_abort latency", fin - acc, W);
        check("post_abort sum", sum, 8'h03);
        @(posedge clk);
        @(negedge clk);

        // Back-to-back with start held high.
        bb_a = '{8'h12, 8'hF0, 8'h80};
        bb_b = '{8'h34, 8'h20, 8'h7F};
        bb_c = '{1'b0, 1'b1, 1'b1};
        bb_s = '{8'h46, 8'h11, 8'h00};
        bb_co = '{1'b0, 1'b1, 1'b1};
        pulse_start(bb_a[0], bb_b[0], bb_c[0], acc);
        start = 1'b1;
        a     = bb_a[1];
        b     = bb_b[1];
        c_in  = bb_c[1];
        prev  = acc;
        for (int i = 0; i < 3; i++) begin
            wait_done(fin, nbusy);
            check($sformatf("b2b%0d period", i), fin - prev, (i == 0) ? W : W + 1);
            check($sformatf("b2b%0d sum", i), sum, bb_s[i]);
            check($sformatf("b2b%0d c_out", i), c_out, bb_co[i]);
            prev = fin;
            if (i == 2) start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d done_width", i), done, 0);
            if (i == 0) begin
                a    = bb_a[2];
                b    = bb_b[2];
                c_in = bb_c[2];
            end
        end
        check("b2b idle after", busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
